if_stage_param: RTL and testbench

- Parametrised instruction-fetch stage: PC register, next-PC selection (sequential or redirect), fixed-latency instruction-memory request interface, and a DEPTH-entry fetch buffer.
- Decouples memory from decode via a valid/ready handshake toward the IF/ID boundary.
- Hazard stalls arrive as backpressure (id_ready low); branch redirects flush all younger fetches.
- Sits between the PC/branch-resolution logic and the decode stage.

---
 rtl/if_pkg.sv | 14 +
 rtl/if_stage_param_if.sv | 28 ++
 rtl/if_stage_param_fetch_fifo.sv | 53 +++++
 rtl/if_stage_param.sv | 92 +++++++++
 tb/tb_if_stage_param.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared defaults and the fetch-buffer entry type for the instruction-fetch stage.
package if_pkg;

  localparam int                  IF_XLEN       = 32;
  localparam int                  IF_INST_BYTES = 4;
  localparam logic [IF_XLEN-1:0]  IF_RESET_PC   = '0;

  // One buffered fetch: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_param_if.sv
// Redirect, instruction-memory and IF/ID handshake signals of the fetch stage.
interface if_stage_param_if #(
  parameter int XLEN = 32
) ();

  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic            id_ready;

  // Fetch stage view.
  modport master (
    input  br_taken, br_target, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_inst, id_pc
  );

  // Environment view: branch unit, instruction memory and decode.
  modport slave (
    output br_taken, br_target, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_inst, id_pc
  );

endinterface

// File: rtl/if_stage_param_fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched instructions with their PCs.
// Pointers wrap naturally because DEPTH is a power of two.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output T                       head
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  // Pointer and occupancy bookkeeping; flush returns to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is pure data and carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage_param.sv
// Instruction-fetch stage: PC register, sequential/redirect next-PC, one-deep
// fixed-latency memory request tracking and a credit-limited fetch buffer.
module if_stage_param
  import if_pkg::*;
#(
  parameter int              XLEN       = IF_XLEN,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(IF_RESET_PC),
  parameter int              INST_BYTES = IF_INST_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  if_stage_param_if.master       bus
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            drop;
  logic [CW-1:0]   count;
  logic [CW-1:0]   credit;
  logic            issue;
  logic            push;
  logic            pop;
  logic            id_valid_int;
  entry_t          head;
  entry_t          push_data;

  // Credits cover both buffered entries and the response still on its way,
  // so a fetch is only issued when its result is guaranteed a slot.
  assign credit = count + CW'(inflight);
  assign issue  = rst_n && !bus.br_taken && (credit < CW'(DEPTH));

  // A redirect kills the response landing this cycle and any pop of the head.
  assign push         = inflight && !drop && !bus.br_taken;
  assign id_valid_int = (count != '0);
  assign pop          = id_valid_int && bus.id_ready && !bus.br_taken;
  assign push_data    = '{pc: req_pc, inst: bus.imem_rdata};

  // --- request stage: PC, outstanding-request and discard control ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else if (bus.br_taken) begin
      pc       <= bus.br_target & ALIGN_MASK;
      inflight <= 1'b0;
      drop     <= inflight;
    end else begin
      inflight <= issue;
      drop     <= 1'b0;
      if (issue) pc <= pc + PC_STEP;
    end
  end

  // PC of the outstanding request, paired with its data on return.
  always_ff @(posedge clk) begin
    if (issue) req_pc <= pc;
  end

  // --- response stage: buffer toward decode ---
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.br_taken),
    .count     (count),
    .head      (head)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.id_valid  = id_valid_int;
  assign bus.id_inst   = id_valid_int ? head.inst : '0;
  assign bus.id_pc     = id_valid_int ? head.pc   : '0;

endmodule

// File: tb/tb_if_stage_param.sv
// Directed bench for the fetch stage: reset state, streaming, backpressure,
// redirects, PC wrap-around and reset in the middle of a full buffer.
module tb_if_stage_param;
  import if_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_stage_param_if #(.XLEN(32)) bus   ();
  if_stage_param_if #(.XLEN(32)) bus_b ();

  if_stage_param #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .INST_BYTES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  if_stage_param #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .INST_BYTES(4)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Memory model: data = address ^ A5A5_0000, one cycle after the request.
  logic [31:0] rsp_a;
  logic [31:0] rsp_b;
  always @(posedge clk) begin
    rsp_a <= bus.imem_addr;
    rsp_b <= bus_b.imem_addr;
  end
  assign bus.imem_rdata   = rsp_a ^ 32'hA5A5_0000;
  assign bus_b.imem_rdata = rsp_b ^ 32'hA5A5_0000;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one cycle, drive inputs 1ns after the edge, sample 1ns later.
  task automatic next(input logic rdy, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    bus.id_ready  = rdy;
    bus.br_taken  = br;
    bus.br_target = tgt;
    #1;
  endtask

  // Reset, then return in cycle 0 after release with id_ready=1.
  task automatic do_reset();
    #1;
    rst_n         = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;
    bus.id_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] b_pc;

    rst_n           = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = '0;
    bus.id_ready    = 1'b1;
    bus_b.br_taken  = 1'b0;
    bus_b.br_target = '0;
    bus_b.id_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_id_inst",  bus.id_inst, 32'h0);
    chk("rst_id_pc",    bus.id_pc,   32'h0);
    chk("rst_req_b",    32'(bus_b.imem_req), 32'd0);

    // Streaming with id_ready=1, plus RESET_PC wrap on the second instance
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      chk("t1_req",  32'(bus.imem_req), 32'd1);
      chk("t1_addr", bus.imem_addr, 32'(4 * c));
      b_pc = 32'hFFFF_FFF8 + 32'(4 * c);
      chk("wrap_addr", bus_b.imem_addr, b_pc);
      if (c < 2) begin
        chk("t1_valid_lat", 32'(bus.id_valid), 32'd0);
      end else begin
        chk("t1_valid", 32'(bus.id_valid), 32'd1);
        chk("t1_pc",    bus.id_pc,   32'(4 * (c - 2)));
        chk("t1_inst",  bus.id_inst, 32'(4 * (c - 2)) ^ 32'hA5A5_0000);
        b_pc = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
        chk("wrap_pc",  bus_b.id_pc, b_pc);
      end
      if (c < 5) next(1'b1, 1'b0, 32'h0);
    end

    // Backpressure from the first valid cycle: fills to 4, then drains in order
    do_reset();
    next(1'b1, 1'b0, 32'h0);                       // c1
    next(1'b0, 1'b0, 32'h0);                       // c2
    chk("t2_pc_c2",   bus.id_pc, 32'h0);
    chk("t2_addr_c2", bus.imem_addr, 32'h8);
    next(1'b0, 1'b0, 32'h0);                       // c3
    chk("t2_req_c3",  32'(bus.imem_req), 32'd1);
    chk("t2_addr_c3", bus.imem_addr, 32'hC);
    for (int c = 4; c < 8; c++) begin
      next(1'b0, 1'b0, 32'h0);
      chk("t2_req_full", 32'(bus.imem_req), 32'd0);
      chk("t2_pc_held",  bus.id_pc, 32'h0);
      chk("t2_valid",    32'(bus.id_valid), 32'd1);
    end
    chk("t2_addr_hold", bus.imem_addr, 32'h10);
    for (int c = 8; c < 13; c++) begin
      next(1'b1, 1'b0, 32'h0);
      chk("t2_drain_pc", bus.id_pc, 32'(4 * (c - 8)));
      if (c == 8) chk("t2_req_c8", 32'(bus.imem_req), 32'd0);
      if (c == 9) begin
        chk("t2_resume_req",  32'(bus.imem_req), 32'd1);
        chk("t2_resume_addr", bus.imem_addr, 32'h10);
      end
    end

    // Redirect with 3 buffered entries and one response in flight
    do_reset();
    next(1'b1, 1'b0, 32'h0);                       // c1
    next(1'b0, 1'b0, 32'h0);                       // c2
    next(1'b0, 1'b0, 32'h0);                       // c3
    next(1'b0, 1'b1, 32'h100);                     // c4: redirect
    chk("t3_req_br", 32'(bus.imem_req), 32'd0);
    next(1'b1, 1'b0, 32'h0);                       // c5
    chk("t3_valid_c5", 32'(bus.id_valid), 32'd0);
    chk("t3_addr_c5",  bus.imem_addr, 32'h100);
    chk("t3_req_c5",   32'(bus.imem_req), 32'd1);
    next(1'b1, 1'b0, 32'h0);                       // c6
    chk("t3_valid_c6", 32'(bus.id_valid), 32'd0);
    next(1'b1, 1'b0, 32'h0);                       // c7
    chk("t3_valid_c7", 32'(bus.id_valid), 32'd1);
    chk("t3_pc_c7",    bus.id_pc, 32'h100);
    chk("t3_inst_c7",  bus.id_inst, 32'h100 ^ 32'hA5A5_0000);
    next(1'b1, 1'b0, 32'h0);                       // c8
    chk("t3_pc_c8",    bus.id_pc, 32'h104);

    // Misaligned target and back-to-back redirects
    next(1'b1, 1'b1, 32'h103);                     // c9
    chk("t4_req_br", 32'(bus.imem_req), 32'd0);
    next(1'b1, 1'b0, 32'h0);                       // c10
    chk("t4_align_addr", bus.imem_addr, 32'h100);
    next(1'b1, 1'b1, 32'h200);                     // c11
    next(1'b1, 1'b1, 32'h300);                     // c12
    chk("t4_req_br2",   32'(bus.imem_req), 32'd0);
    chk("t4_valid_c12", 32'(bus.id_valid), 32'd0);
    next(1'b1, 1'b0, 32'h0);                       // c13
    chk("t4_addr_c13",  bus.imem_addr, 32'h300);
    chk("t4_valid_c13", 32'(bus.id_valid), 32'd0);
    next(1'b1, 1'b0, 32'h0);                       // c14
    chk("t4_valid_c14", 32'(bus.id_valid), 32'd0);
    next(1'b1, 1'b0, 32'h0);                       // c15
    chk("t4_pc_c15",    bus.id_pc, 32'h300);
    next(1'b1, 1'b0, 32'h0);                       // c16
    chk("t4_pc_c16",    bus.id_pc, 32'h304);

    // Asynchronous reset with a full buffer
    do_reset();
    next(1'b1, 1'b0, 32'h0);                       // c1
    for (int c = 2; c < 7; c++) next(1'b0, 1'b0, 32'h0);
    chk("t6_full_valid", 32'(bus.id_valid), 32'd1);
    chk("t6_full_req",   32'(bus.imem_req), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.id_valid), 32'd0);
    chk("t6_rst_req",   32'(bus.imem_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.id_ready = 1'b1;
    #1;                                            // c0
    chk("t6_restart_req",  32'(bus.imem_req), 32'd1);
    chk("t6_restart_addr", bus.imem_addr, 32'h0);
    chk("t6_valid_c0",     32'(bus.id_valid), 32'd0);
    next(1'b1, 1'b0, 32'h0);                       // c1
    chk("t6_valid_c1",     32'(bus.id_valid), 32'd0);
    next(1'b1, 1'b0, 32'h0);                       // c2
    chk("t6_pc_c2",        bus.id_pc, 32'h0);
    chk("t6_inst_c2",      bus.id_inst, 32'hA5A5_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
